demux_router: RTL and testbench
===============================

# demux_router

Registered 1-to-N demultiplexer with a valid/ready handshake on every port. It is the fan-out counterpart of the datapath's 2:1 and N:1 selectors. A single producer presents a data word and a destination select. The block steers the word into a one-entry holding register for the chosen lane, and each lane drains independently to its own consumer. It sits between the pipeline's result bus and per-unit consumers such as the write-back, store-data and flag-update paths. It decouples their back-pressure from the producer.

## Interface
Parameters:
- WIDTH, 64, data word width in bits.
- N, 4, number of output lanes; legal range 2..8.
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_W  destination lane index.
- out_valid  output  N  bit k: lane k holds a word.
- out_ready  input  N  bit k: consumer k takes lane k's word this cycle.
- out_data  output  N*WIDTH  lane k word on bits [k*WIDTH +: WIDTH].
- err_cnt  output  8  count of words dropped for an out-of-range select.

## Operation
- Each lane k has a full flag (full[k], driven out as out_valid[k]) and a data register (driven out as lane k of out_data).
- A word is accepted (accept) when in_valid & in_ready at a rising edge.
- in_ready (combinational):
  - When in_sel < N: in_ready = ~full[in_sel] | out_ready[in_sel].
  - When in_sel >= N: in_ready = 1.
  - in_ready never depends on in_valid.
- On accept with in_sel < N: lane in_sel data register loads in_data and full[in_sel] is set.
- On accept with in_sel >= N: the word is discarded, no lane changes, and err_cnt increments. err_cnt saturates at 255 and holds there.
- Lane k pops when full[k] & out_ready[k] at a rising edge. full[k] clears unless the same edge also accepts into lane k.
- Push and pop on the same lane in the same cycle: the new word replaces the old one and full stays 1. This gives full throughput, one word per cycle per lane.
- Lanes are independent. A pop on lane j never affects lane k, and a stalled lane blocks the producer only while in_sel points at it.
- out_data lane k is held stable whenever full[k]=1 and no push into lane k occurs.
- out_data lane k is don't-care to consumers when full[k]=0. It retains its last value; it is not cleared.
- No word is ever duplicated, reordered within a lane, or lost, except for out-of-range drops.

## Timing
- Reset (reset_n=0, asynchronous assert): out_valid=0, all out_data=0, err_cnt=0.
  - in_ready then reads 1 for any in_sel.
  - Deassertion is synchronous to clk and is released externally.
- Reset mid-operation discards all held words immediately and does not wait for an edge.
- Latency: a word accepted at edge t shows out_valid[k]=1 and valid out_data after edge t. It is consumable at edge t+1.
- No combinational path from in_valid or in_data to any output. The only combinational path is in_sel/out_ready to in_ready.
- Sustained throughput is 1 word/cycle when the target consumer holds out_ready=1.
- A select that changes while in_valid=0 has no effect.

## Test plan
- Reset, then route:
  - Stimulus: assert reset_n=0 mid-run with lanes 1 and 3 full.
  - Required during reset: all out_valid=0, out_data=0, err_cnt=0, in_ready=1.
  - Stimulus after release: send 0xAAAA_0000_0000_0001 to lane 2.
  - Required after release: out_valid=4'b0100 one cycle later, with lane 2 data matching.
- Back-pressure:
  - Stimulus: out_ready=0, fill lane 0 with 0x11, then present 0x22 to lane 0.
  - Required: in_ready=0 and lane 0 holds 0x11.
  - Stimulus: raise out_ready[0].
  - Required: 0x11 pops and 0x22 loads on the same edge; out_valid[0] stays 1.
- Independence:
  - Stimulus: lane 1 stalled and full; send 0x33 to lane 3.
  - Required: in_ready=1, lane 3 gets 0x33, lane 1 is unchanged.
- Streaming:
  - Stimulus: 16 back-to-back words 0..15 round-robin over lanes 0..3, all out_ready=1.
  - Required: in_ready=1 every cycle, and each lane k emits k, k+4, k+8, k+12 in order.
- Out-of-range select:
  - Stimulus: N=3, send 300 words with in_sel=3.
  - Required: in_ready=1 throughout, no out_valid, err_cnt saturates at 255.
- Same-cycle push/pop with a random scoreboard:
  - Stimulus: random valid/ready/sel for 10k cycles against a reference queue.
  - Required: zero mismatches, and no word is lost or duplicated.

Source files
------------

// File: rtl/demux_router.sv
// Registered 1-to-N demultiplexer: one-entry holding register per lane, each lane
// drains independently; out-of-range selects are dropped and counted.
module demux_router #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [7:0]           err_cnt
);

  localparam logic [7:0] ErrMax = 8'hFF;

  logic [N-1:0]       full_q, full_d;
  logic [N*WIDTH-1:0] data_q, data_d;
  logic [7:0]         err_q, err_d;
  logic [N-1:0]       push, pop;
  logic               sel_ok;
  logic               accept;

  // Ready only looks at the selected lane; an unmatched select is always accepted.
  always_comb begin
    in_ready = 1'b1;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_ok   = 1'b1;
        in_ready = ~full_q[k] | out_ready[k];
      end
    end
  end

  assign accept = in_valid & in_ready;

  // Push wins over pop so a same-cycle push/pop keeps the lane full with the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    err_d  = err_q;
    pop    = full_q & out_ready;
    push   = '0;
    for (int k = 0; k < N; k++) begin
      push[k] = accept & sel_ok & (in_sel == SEL_W'(k));
      if (push[k]) begin
        full_d[k]                  = 1'b1;
        data_d[k*WIDTH +: WIDTH]   = in_data;
      end else if (pop[k]) begin
        full_d[k] = 1'b0;
      end
    end
    if (accept && !sel_ok && (err_q != ErrMax)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_demux_router.sv
// Directed + random scoreboard bench for demux_router (N=4 main instance, N=3 for drop path).
module tb_demux_router;

  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid, out_ready;
  logic [4*W-1:0] out_data;
  logic [7:0]    err_cnt;

  logic          in_valid3, in_ready3;
  logic [W-1:0]  in_data3;
  logic [1:0]    in_sel3;
  logic [2:0]    out_valid3, out_ready3;
  logic [3*W-1:0] out_data3;
  logic [7:0]    err_cnt3;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] q [4][$];

  always #5 clk = ~clk;

  demux_router #(.WIDTH(W), .N(4)) u4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_cnt(err_cnt)
  );

  demux_router #(.WIDTH(W), .N(3)) u3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .err_cnt(err_cnt3)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on u4, check against the queue model, then advance to posedge+1.
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] r);
    logic       exp_rdy;
    logic [3:0] exp_v;
    logic [W-1:0] e;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    for (int k = 0; k < 4; k++) exp_v[k] = (q[k].size() != 0);
    exp_rdy = ~exp_v[s] | r[s];
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    for (int k = 0; k < 4; k++) begin
      if (exp_v[k] && r[k]) begin
        e = q[k].pop_front();
        chk("lane_data", out_data[k*W +: W], e);
      end
    end
    if (v && exp_rdy) q[s].push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0; in_sel  = '0; in_data  = '0; out_ready  = '0;
    in_valid3  = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_err_cnt", 64'(err_cnt), 64'd0);

    // Fill lanes 1 and 3, then reset asynchronously mid-cycle.
    step(1'b1, 2'd1, 64'h0101, 4'h0);
    step(1'b1, 2'd3, 64'h0303, 4'h0);
    step(1'b0, 2'd0, 64'h0, 4'h0);
    chk("pre_reset_valid", 64'(out_valid), 64'h0A);
    #2 reset_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 4; k++) chk("rst_out_data", out_data[k*W +: W], 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_err_cnt3", 64'(err_cnt3), 64'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Route after release: visible one edge after acceptance.
    step(1'b1, 2'd2, 64'hAAAA_0000_0000_0001, 4'h0);
    chk("route_valid", 64'(out_valid), 64'h4);
    chk("route_data", out_data[2*W +: W], 64'hAAAA_0000_0000_0001);
    step(1'b0, 2'd0, 64'h0, 4'hF);

    // Back-pressure on lane 0, then simultaneous pop/push.
    step(1'b1, 2'd0, 64'h11, 4'h0);
    step(1'b1, 2'd0, 64'h22, 4'h0);
    chk("bp_hold_data", out_data[0 +: W], 64'h11);
    step(1'b1, 2'd0, 64'h22, 4'h1);
    chk("bp_valid_kept", 64'(out_valid[0]), 64'd1);
    chk("bp_new_data", out_data[0 +: W], 64'h22);
    step(1'b0, 2'd0, 64'h0, 4'hF);

    // Independence: lane 1 stalled, lane 3 still accepts.
    step(1'b1, 2'd1, 64'h44, 4'h0);
    step(1'b1, 2'd3, 64'h33, 4'h0);
    chk("ind_lane1", out_data[1*W +: W], 64'h44);
    chk("ind_lane3", out_data[3*W +: W], 64'h33);
    chk("ind_valid", 64'(out_valid), 64'hA);
    step(1'b0, 2'd0, 64'h0, 4'hF);

    // Streaming round-robin at full rate.
    for (int i = 0; i < 16; i++) step(1'b1, 2'(i % 4), 64'(i), 4'hF);
    step(1'b0, 2'd0, 64'h0, 4'hF);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Out-of-range selects on the N=3 instance saturate the drop counter.
    in_sel3 = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_valid3 = 1'b1;
      in_data3  = 64'(i);
      #1;
      chk("oor_in_ready", 64'(in_ready3), 64'd1);
      chk("oor_out_valid", 64'(out_valid3), 64'd0);
      @(posedge clk);
      #1;
      chk("oor_err_cnt", 64'(err_cnt3), 64'((i + 1 > 255) ? 255 : i + 1));
    end
    in_sel3  = 2'd2;
    in_data3 = 64'h5A5A;
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    chk("top_lane_valid", 64'(out_valid3), 64'h4);
    chk("top_lane_data", out_data3[2*W +: W], 64'h5A5A);
    chk("err_cnt_held", 64'(err_cnt3), 64'd255);

    // Random traffic against the per-lane scoreboard.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, 4'($urandom));
    end
    step(1'b0, 2'd0, 64'h0, 4'hF);
    chk("rand_drained", 64'(out_valid), 64'd0);
    chk("rand_err_cnt", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
